// File: rtl/eth_pkg.sv
// Shared definitions for the GMII transmit path: framer states, wire constants, CRC-32 constants.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_PAYLOAD, ST_PAD, ST_FCS, ST_DRAIN, ST_IFG
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REV  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          ETH_MIN_PAYLOAD = 60;
  localparam int          ETH_IFG_BYTES   = 12;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } gmii_tx_t;

  function automatic gmii_tx_t gmii_byte(input logic [7:0] d, input logic er);
    return '{txd: d, en: 1'b1, er: er};
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB-first).
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REV) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/eth_gmii_tx_framer.sv
// Byte-stream to GMII transmit framer: preamble/SFD, zero padding, CRC-32 FCS, inter-frame gap.
module eth_gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD    = ETH_MIN_PAYLOAD,
  parameter int IFG_BYTES      = ETH_IFG_BYTES,
  parameter bit ENABLE_PADDING = 1'b1
) (
  input  logic        clk_int,
  input  logic        rst_int_n,
  input  logic [7:0]  tx_axis_tdata,
  input  logic        tx_axis_tvalid,
  output logic        tx_axis_tready,
  input  logic        tx_axis_tlast,
  input  logic        tx_axis_tuser,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [31:0] tx_fcs_reg,
  output logic        tx_busy,
  output logic        tx_frame_done,
  output logic        tx_underrun
);
  localparam int IFG_W = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

  tx_state_e        state_q, state_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [10:0]      pay_cnt_q, pay_cnt_d, pay_inc;
  logic [1:0]       fcs_cnt_q, fcs_cnt_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [31:0]      crc_q, crc_d, crc_nx, crc_seed, fcs_val, fcs_reg_d;
  logic [7:0]       crc_data;
  gmii_tx_t         gmii_q, gmii_d;
  logic             done_d, urun_d, short_frame;

  assign tx_axis_tready = (state_q == ST_SFD) || (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);

  // SFD cycle carries the first payload byte, so the seed is swapped in there.
  assign crc_seed = (state_q == ST_SFD) ? CRC32_INIT : crc_q;
  assign crc_data = (state_q == ST_PAD) ? 8'h00 : tx_axis_tdata;
  assign fcs_val  = ~crc_q;
  assign pay_inc  = (pay_cnt_q == 11'h7FF) ? pay_cnt_q : pay_cnt_q + 11'd1;
  assign short_frame = ENABLE_PADDING && (({1'b0, pay_cnt_q} + 12'd1) < 12'(MIN_PAYLOAD));

  eth_crc32_d8 u_crc (.crc_in(crc_seed), .data(crc_data), .crc_out(crc_nx));

  // gmii_d is what the wire carries next cycle, hence the one-beat lag on payload.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = '0;
    pay_cnt_d = pay_cnt_q;
    fcs_cnt_d = '0;
    ifg_cnt_d = '0;
    crc_d     = crc_q;
    gmii_d    = '0;
    done_d    = 1'b0;
    urun_d    = 1'b0;
    fcs_reg_d = tx_fcs_reg;
    case (state_q)
      ST_IDLE: begin
        pay_cnt_d = '0;
        if (tx_axis_tvalid) begin
          state_d = ST_PREAMBLE;
          gmii_d  = gmii_byte(ETH_PREAMBLE, 1'b0);
        end
      end
      ST_PREAMBLE: begin
        pre_cnt_d = pre_cnt_q + 3'd1;
        gmii_d    = gmii_byte(ETH_PREAMBLE, 1'b0);
        if (pre_cnt_q == 3'd6) begin
          state_d = ST_SFD;
          gmii_d  = gmii_byte(ETH_SFD, 1'b0);
        end
      end
      ST_SFD, ST_PAYLOAD: begin
        if (tx_axis_tvalid) begin
          crc_d     = crc_nx;
          pay_cnt_d = pay_inc;
          gmii_d    = gmii_byte(tx_axis_tdata, tx_axis_tlast && tx_axis_tuser);
          if (!tx_axis_tlast)    state_d = ST_PAYLOAD;
          else if (tx_axis_tuser) state_d = ST_IFG;
          else if (short_frame)  state_d = ST_PAD;
          else                   state_d = ST_FCS;
        end else begin
          gmii_d  = gmii_byte(8'h00, 1'b1);
          urun_d  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_PAD: begin
        crc_d     = crc_nx;
        pay_cnt_d = pay_inc;
        gmii_d    = gmii_byte(8'h00, 1'b0);
        if (!short_frame) state_d = ST_FCS;
      end
      ST_FCS: begin
        fcs_cnt_d = fcs_cnt_q + 2'd1;
        gmii_d    = gmii_byte(fcs_val[{fcs_cnt_q, 3'b000} +: 8], 1'b0);
        if (fcs_cnt_q == 2'd3) begin
          done_d    = 1'b1;
          fcs_reg_d = fcs_val;
          state_d   = ST_IFG;
        end
      end
      ST_DRAIN: begin
        if (tx_axis_tvalid && tx_axis_tlast) state_d = ST_IFG;
      end
      ST_IFG: begin
        ifg_cnt_d = ifg_cnt_q + 1'b1;
        if (ifg_cnt_q == IFG_W'(IFG_BYTES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= ST_IDLE;
      pre_cnt_q     <= '0;
      pay_cnt_q     <= '0;
      fcs_cnt_q     <= '0;
      ifg_cnt_q     <= '0;
      crc_q         <= CRC32_INIT;
      gmii_q        <= '0;
      tx_fcs_reg    <= '0;
      tx_busy       <= 1'b0;
      tx_frame_done <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      fcs_cnt_q     <= fcs_cnt_d;
      ifg_cnt_q     <= ifg_cnt_d;
      crc_q         <= crc_d;
      gmii_q        <= gmii_d;
      tx_fcs_reg    <= fcs_reg_d;
      tx_busy       <= (state_d != ST_IDLE);
      tx_frame_done <= done_d;
      tx_underrun   <= urun_d;
    end
  end

  assign gmii_txd   = gmii_q.txd;
  assign gmii_tx_en = gmii_q.en;
  assign gmii_tx_er = gmii_q.er;

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Directed bench for the GMII transmit framer: padded and unpadded instances share one stream driver.
module tb_eth_gmii_tx_framer;
  typedef logic [7:0] byte_q_t[$];
  typedef struct { int len; logic [7:0] seed; int exp_pad; int exp_en; } vec_t;

  logic clk_int = 1'b0, rst_int_n = 1'b0;
  logic [7:0] tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, sel_np = 1'b0;

  logic p_tready, p_en, p_er, p_busy, p_done, p_urun;
  logic [7:0] p_txd; logic [31:0] p_fcs;
  logic np_tready, np_en, np_er, np_busy, np_done, np_urun;
  logic [7:0] np_txd; logic [31:0] np_fcs;

  int nvec = 0, nmis = 0;
  byte_q_t p_wire, np_wire;
  int gap_q[$];
  int p_en_cyc = 0, p_er_cnt = 0, p_done_cnt = 0, p_urun_cnt = 0, p_acc_cnt = 0, np_done_cnt = 0;
  int low_run = 0; bit seen_high = 0; logic p_last_er = 1'b0;

  always #4 clk_int = ~clk_int;

  eth_gmii_tx_framer dut (
    .clk_int(clk_int), .rst_int_n(rst_int_n),
    .tx_axis_tdata(tdata), .tx_axis_tvalid(tvalid & ~sel_np), .tx_axis_tready(p_tready),
    .tx_axis_tlast(tlast), .tx_axis_tuser(tuser),
    .gmii_txd(p_txd), .gmii_tx_en(p_en), .gmii_tx_er(p_er), .tx_fcs_reg(p_fcs),
    .tx_busy(p_busy), .tx_frame_done(p_done), .tx_underrun(p_urun));

  eth_gmii_tx_framer #(.ENABLE_PADDING(1'b0)) dut_np (
    .clk_int(clk_int), .rst_int_n(rst_int_n),
    .tx_axis_tdata(tdata), .tx_axis_tvalid(tvalid & sel_np), .tx_axis_tready(np_tready),
    .tx_axis_tlast(tlast), .tx_axis_tuser(tuser),
    .gmii_txd(np_txd), .gmii_tx_en(np_en), .gmii_tx_er(np_er), .tx_fcs_reg(np_fcs),
    .tx_busy(np_busy), .tx_frame_done(np_done), .tx_underrun(np_urun));

  always @(negedge clk_int) begin
    if (p_en) begin
      p_wire.push_back(p_txd);
      p_en_cyc++;
      if (p_er) p_er_cnt++;
      p_last_er = p_er;
      if (seen_high && low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
      seen_high = 1'b1;
    end else low_run++;
    if (p_done) p_done_cnt++;
    if (p_urun) p_urun_cnt++;
    if (tvalid && !sel_np && p_tready) p_acc_cnt++;
    if (np_en) np_wire.push_back(np_txd);
    if (np_done) np_done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_wire(input string name, input byte_q_t act, input byte_q_t exp);
    int n;
    chk({name, "_len"}, 32'(act.size()), 32'(exp.size()));
    n = (act.size() < exp.size()) ? act.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", name, i), 32'(act[i]), 32'(exp[i]));
  endtask

  function automatic logic [31:0] crc_ref(input byte_q_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i])
      for (int b = 0; b < 8; b++)
        c = {1'b0, c[31:1]} ^ ((c[0] ^ d[i][b]) ? 32'hEDB88320 : 32'h0);
    return ~c;
  endfunction

  function automatic byte_q_t hdr();
    byte_q_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    return q;
  endfunction

  function automatic byte_q_t frame_model(input byte_q_t pl, input bit pad_en);
    byte_q_t q, body;
    logic [31:0] f;
    body = pl;
    while (pad_en && body.size() < 60) body.push_back(8'h00);
    q = hdr();
    foreach (body[i]) q.push_back(body[i]);
    f = crc_ref(body);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    return q;
  endfunction

  function automatic byte_q_t make_payload(input int len, input logic [7:0] seed);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(seed + 8'(i * 13));
    return q;
  endfunction

  function automatic logic [31:0] fcs_of(input byte_q_t w);
    return {w[w.size()-1], w[w.size()-2], w[w.size()-3], w[w.size()-4]};
  endfunction

  // Beats advance only on tvalid&tready sampled mid-cycle; stall_len cycles of tvalid=0 at beat stall_at.
  task automatic send(input byte_q_t d, input bit abort, input int stall_at, input int stall_len);
    int i = 0, guard = 0, stalled = 0;
    bit acc;
    while (i < d.size()) begin
      if (i == stall_at && stalled < stall_len) begin
        tvalid = 1'b0;
        stalled++;
      end else begin
        tvalid = 1'b1;
        tdata  = d[i];
        tlast  = (i == d.size() - 1);
        tuser  = abort && (i == d.size() - 1);
      end
      @(negedge clk_int);
      acc = tvalid && (sel_np ? np_tready : p_tready);
      @(posedge clk_int); #1;
      if (acc) i++;
      guard++;
      if (guard > 5000) begin
        nvec++; nmis++;
        $display("FAIL send_timeout: %0d of %0d beats accepted", i, d.size());
        break;
      end
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk_int); n++; end while ((sel_np ? np_busy : p_busy) && n < 1000);
    if (n >= 1000) begin
      nvec++; nmis++;
      $display("FAIL %s_idle_timeout: tx_busy still 1 after %0d cycles, want 0", name, n);
    end
    @(posedge clk_int); #1;
  endtask

  initial begin
    vec_t vt[5];
    byte_q_t pl, pl2, exp, exp2;
    int s, e0, d0, a0, r0, u0, g0;
    logic [31:0] last_fcs;

    vt[0] = '{1,  8'hAB, 59, 72};
    vt[1] = '{20, 8'h01, 40, 72};
    vt[2] = '{59, 8'h33, 1,  72};
    vt[3] = '{60, 8'h77, 0,  72};
    vt[4] = '{61, 8'hF0, 0,  73};

    repeat (3) @(posedge clk_int); #1;
    chk("rst_tready", 32'(p_tready), 0);
    chk("rst_tx_en", 32'(p_en), 0);
    chk("rst_tx_er", 32'(p_er), 0);
    chk("rst_txd", 32'(p_txd), 0);
    chk("rst_busy", 32'(p_busy), 0);
    chk("rst_fcs_reg", p_fcs, 0);
    chk("rst_done", 32'(p_done), 0);
    chk("rst_underrun", 32'(p_urun), 0);
    @(negedge clk_int) rst_int_n = 1'b1;
    @(posedge clk_int); #1;

    // Unpadded check string: FCS is the standard CRC-32 check value.
    sel_np = 1'b1;
    pl  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
            8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    s = np_wire.size(); d0 = np_done_cnt;
    send(pl, 1'b0, -1, 0);
    wait_idle("np");
    chk_wire("np_wire", np_wire[s:$], exp);
    chk("np_fcs_reg", np_fcs, 32'hCBF43926);
    chk("np_done_pulses", 32'(np_done_cnt - d0), 1);
    sel_np = 1'b0;

    foreach (vt[k]) begin
      pl  = make_payload(vt[k].len, vt[k].seed);
      exp = frame_model(pl, 1'b1);
      s = p_wire.size(); e0 = p_en_cyc; d0 = p_done_cnt; a0 = p_acc_cnt; r0 = p_er_cnt;
      send(pl, 1'b0, -1, 0);
      wait_idle($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_en_cycles", k), 32'(p_en_cyc - e0), 32'(vt[k].exp_en));
      chk($sformatf("vec%0d_pad_bytes", k), 32'(p_wire.size() - s - 12 - vt[k].len), 32'(vt[k].exp_pad));
      chk_wire($sformatf("vec%0d_wire", k), p_wire[s:$], exp);
      last_fcs = fcs_of(exp);
      chk($sformatf("vec%0d_fcs_reg", k), p_fcs, last_fcs);
      chk($sformatf("vec%0d_done", k), 32'(p_done_cnt - d0), 1);
      chk($sformatf("vec%0d_accepted", k), 32'(p_acc_cnt - a0), 32'(vt[k].len));
      chk($sformatf("vec%0d_er", k), 32'(p_er_cnt - r0), 0);
    end

    // Back-to-back 64-byte frames, tvalid never dropped.
    pl  = make_payload(64, 8'h10);
    pl2 = make_payload(64, 8'h80);
    exp = frame_model(pl, 1'b1); exp2 = frame_model(pl2, 1'b1);
    foreach (exp2[i]) exp.push_back(exp2[i]);
    s = p_wire.size(); d0 = p_done_cnt; a0 = p_acc_cnt; g0 = gap_q.size();
    send(pl, 1'b0, -1, 0);
    send(pl2, 1'b0, -1, 0);
    wait_idle("b2b");
    chk_wire("b2b_wire", p_wire[s:$], exp);
    chk("b2b_gap_count", 32'(gap_q.size() - g0), 2);
    chk("b2b_gap_len", 32'(gap_q[$]), 12);
    chk("b2b_done", 32'(p_done_cnt - d0), 2);
    chk("b2b_accepted", 32'(p_acc_cnt - a0), 128);
    last_fcs = fcs_of(exp);
    chk("b2b_fcs_reg", p_fcs, last_fcs);

    // Underrun after 10 payload bytes.
    pl  = make_payload(20, 8'h40);
    exp = hdr();
    for (int i = 0; i < 10; i++) exp.push_back(pl[i]);
    exp.push_back(8'h00);
    s = p_wire.size(); e0 = p_en_cyc; d0 = p_done_cnt; a0 = p_acc_cnt; r0 = p_er_cnt; u0 = p_urun_cnt;
    send(pl, 1'b0, 10, 5);
    wait_idle("urun");
    chk_wire("urun_wire", p_wire[s:$], exp);
    chk("urun_en_cycles", 32'(p_en_cyc - e0), 19);
    chk("urun_pulses", 32'(p_urun_cnt - u0), 1);
    chk("urun_er_cycles", 32'(p_er_cnt - r0), 1);
    chk("urun_er_last", 32'(p_last_er), 1);
    chk("urun_done", 32'(p_done_cnt - d0), 0);
    chk("urun_fcs_reg", p_fcs, last_fcs);
    chk("urun_accepted", 32'(p_acc_cnt - a0), 20);

    // Abort on byte 20.
    pl  = make_payload(20, 8'hC0);
    exp = hdr();
    foreach (pl[i]) exp.push_back(pl[i]);
    s = p_wire.size(); e0 = p_en_cyc; d0 = p_done_cnt; r0 = p_er_cnt; u0 = p_urun_cnt;
    send(pl, 1'b1, -1, 0);
    wait_idle("abort");
    chk_wire("abort_wire", p_wire[s:$], exp);
    chk("abort_en_cycles", 32'(p_en_cyc - e0), 28);
    chk("abort_er_cycles", 32'(p_er_cnt - r0), 1);
    chk("abort_er_last", 32'(p_last_er), 1);
    chk("abort_done", 32'(p_done_cnt - d0), 0);
    chk("abort_underrun", 32'(p_urun_cnt - u0), 0);
    chk("abort_fcs_reg", p_fcs, last_fcs);

    // Asynchronous reset in the middle of the payload.
    tdata = 8'h5A; tvalid = 1'b1; tlast = 1'b0; tuser = 1'b0;
    repeat (20) @(posedge clk_int);
    #2;
    chk("rstmid_pre_en", 32'(p_en), 1);
    chk("rstmid_pre_busy", 32'(p_busy), 1);
    rst_int_n = 1'b0;
    #1;
    chk("rstmid_en", 32'(p_en), 0);
    chk("rstmid_tready", 32'(p_tready), 0);
    chk("rstmid_busy", 32'(p_busy), 0);
    chk("rstmid_fcs_reg", p_fcs, 0);
    tvalid = 1'b0;
    @(negedge clk_int);
    @(negedge clk_int) rst_int_n = 1'b1;
    @(posedge clk_int); #1;
    pl  = make_payload(5, 8'hE7);
    exp = frame_model(pl, 1'b1);
    s = p_wire.size(); d0 = p_done_cnt;
    send(pl, 1'b0, -1, 0);
    wait_idle("post_rst");
    chk_wire("post_rst_wire", p_wire[s:$], exp);
    chk("post_rst_fcs_reg", p_fcs, fcs_of(exp));
    chk("post_rst_done", 32'(p_done_cnt - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
